// File: rtl/ai_player_ctl.sv
// ai_player_ctl -- computer opponent for the air-hockey table.
//
// Drives the player-2 striker centre into the ball controller. The striker
// moves at most 1 px per axis per movement tick. Its target comes from a
// four-state FSM (HOME / DEFEND / ATTACK / GOAL_HOLD), and every target is
// clamped to the right half of the table.
//
// Handshake / timing contract: there is no valid/ready pair. The ball position
// and scores are level inputs sampled by the clock. Ball inputs matter only on
// tick cycles, when tick_cnt == STEP_DIV-1. A change on either score input is
// acted on in the very next cycle, whether or not that cycle is a tick.
//
// Ports:
//   clk_in          system clock
//   rst_n           synchronous reset, active low
//   enable          AI active; when low the striker walks back home
//   xpos_ball       ball centre x (12 bits)
//   ypos_ball       ball centre y (12 bits)
//   player_1_score  score from the ball controller (4 bits)
//   player_2_score  score from the ball controller (4 bits)
//   xpos_player_2   registered striker centre x (12 bits)
//   ypos_player_2   registered striker centre y (12 bits)
//   ai_state        FSM state: 0 HOME, 1 DEFEND, 2 ATTACK, 3 GOAL_HOLD
module ai_player_ctl #(
  parameter int PLAYERS_RADIUS = 20,
  parameter int RADIUS_BALL    = 10,
  parameter int STEP_DIV       = 400000,
  parameter int HOLD_TICKS     = 250,
  parameter int ATTACK_TICKS   = 300,
  parameter int HOME_X         = 900,
  parameter int HOME_Y         = 362,
  parameter int CENTER_X       = 512,
  parameter int ATTACK_X       = 700,
  parameter int X_MIN          = 532,
  parameter int X_MAX          = 961,
  parameter int Y_MIN          = 64,
  parameter int Y_MAX          = 707,
  parameter int GOAL_Y_MIN     = 285,
  parameter int GOAL_Y_MAX     = 431
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] xpos_ball,
  input  logic [11:0] ypos_ball,
  input  logic [3:0]  player_1_score,
  input  logic [3:0]  player_2_score,
  output logic [11:0] xpos_player_2,
  output logic [11:0] ypos_player_2,
  output logic [1:0]  ai_state
);

  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int AW = (ATTACK_TICKS > 0) ? $clog2(ATTACK_TICKS + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
  localparam logic [AW-1:0] ATT_LAST  = AW'(ATTACK_TICKS - 1);

  localparam logic [11:0] HOME_X12   = 12'(HOME_X);
  localparam logic [11:0] HOME_Y12   = 12'(HOME_Y);
  localparam logic [11:0] CENTER_X12 = 12'(CENTER_X);
  localparam logic [11:0] ATTACK_X12 = 12'(ATTACK_X);
  localparam logic [12:0] ATT_OFS    = 13'((PLAYERS_RADIUS + RADIUS_BALL) / 2);
  localparam logic [12:0] X_MIN13    = 13'(X_MIN);
  localparam logic [12:0] X_MAX13    = 13'(X_MAX);
  localparam logic [12:0] Y_MIN13    = 13'(Y_MIN);
  localparam logic [12:0] Y_MAX13    = 13'(Y_MAX);
  localparam logic [12:0] GY_MIN13   = 13'(GOAL_Y_MIN);
  localparam logic [12:0] GY_MAX13   = 13'(GOAL_Y_MAX);

  typedef enum logic [1:0] {
    ST_HOME   = 2'd0,
    ST_DEFEND = 2'd1,
    ST_ATTACK = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t        state, next_state;
  logic [TW-1:0] tick_cnt;
  logic [HW-1:0] hold_cnt;
  logic [AW-1:0] attack_cnt;
  logic [11:0]   prev_x;
  logic [3:0]    p1_q, p2_q;
  logic [12:0]   tgt_x, tgt_y;
  logic          tick, goal, approaching;

  function automatic logic [12:0] clamp13(input logic [12:0] v,
                                          input logic [12:0] lo,
                                          input logic [12:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  function automatic logic [11:0] step_to(input logic [11:0] p,
                                          input logic [12:0] t);
    if ({1'b0, p} < t)      return p + 12'd1;
    else if ({1'b0, p} > t) return p - 12'd1;
    else                    return p;
  endfunction

  assign tick        = (tick_cnt == TICK_LAST);
  assign goal        = (player_1_score != p1_q) || (player_2_score != p2_q);
  assign approaching = (xpos_ball > prev_x);

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_n) state <= ST_HOME;
    else        state <= next_state;
  end

  // Next-state logic: a goal overrides everything, even on a tick cycle
  always_comb begin
    next_state = state;
    if (goal) begin
      next_state = ST_HOLD;
    end else if (tick) begin
      case (state)
        ST_HOME:
          if (enable && xpos_ball >= CENTER_X12) next_state = ST_DEFEND;
        ST_DEFEND:
          if (!enable || xpos_ball < CENTER_X12)               next_state = ST_HOME;
          else if (xpos_ball >= ATTACK_X12 && !approaching)    next_state = ST_ATTACK;
        ST_ATTACK:
          if (!enable || xpos_ball < CENTER_X12) next_state = ST_HOME;
          else if (attack_cnt == ATT_LAST)       next_state = ST_DEFEND;
        ST_HOLD:
          if (hold_cnt == HW'(1)) next_state = ST_HOME;
        default: next_state = ST_HOME;
      endcase
    end
  end

  // Output / target logic. The ATTACK x sum is formed in 13 bits so a ball near
  // the right wall cannot wrap before the clamp.
  always_comb begin
    ai_state = state;
    tgt_x    = {1'b0, HOME_X12};
    tgt_y    = {1'b0, HOME_Y12};
    case (state)
      ST_DEFEND: tgt_y = clamp13({1'b0, ypos_ball}, GY_MIN13, GY_MAX13);
      ST_ATTACK: begin
        tgt_x = {1'b0, xpos_ball} + ATT_OFS;
        tgt_y = {1'b0, ypos_ball};
      end
      default: ;
    endcase
    tgt_x = clamp13(tgt_x, X_MIN13, X_MAX13);
    tgt_y = clamp13(tgt_y, Y_MIN13, Y_MAX13);
  end

  // Datapath: tick divider, ball history, score copies, counters, position
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      tick_cnt      <= '0;
      hold_cnt      <= '0;
      attack_cnt    <= '0;
      prev_x        <= '0;
      p1_q          <= player_1_score;
      p2_q          <= player_2_score;
      xpos_player_2 <= HOME_X12;
      ypos_player_2 <= HOME_Y12;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) prev_x <= xpos_ball;

      if (goal) begin
        p1_q          <= player_1_score;
        p2_q          <= player_2_score;
        hold_cnt      <= HOLD_LOAD;
        xpos_player_2 <= HOME_X12;
        ypos_player_2 <= HOME_Y12;
      end else if (tick) begin
        if (state == ST_HOLD) begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end else begin
          xpos_player_2 <= step_to(xpos_player_2, tgt_x);
          ypos_player_2 <= step_to(ypos_player_2, tgt_y);
        end
        if (state != ST_ATTACK && next_state == ST_ATTACK) attack_cnt <= '0;
        else if (state == ST_ATTACK)                        attack_cnt <= attack_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ai_player_ctl.sv
// Directed bench for ai_player_ctl, built with STEP_DIV=4, HOLD_TICKS=3 and
// ATTACK_TICKS=50. Every expected striker position and state is worked out by
// hand from the movement rules. Each check packs {x, y, state} into a single
// word.
module tb_ai_player_ctl;

  localparam int SD = 4;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] xpos_ball, ypos_ball;
  logic [3:0]  player_1_score, player_2_score;
  logic [11:0] xpos_player_2, ypos_player_2;
  logic [1:0]  ai_state;

  logic [25:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  ai_player_ctl #(
    .STEP_DIV(SD),
    .HOLD_TICKS(3),
    .ATTACK_TICKS(50)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .enable(enable),
    .xpos_ball(xpos_ball),
    .ypos_ball(ypos_ball),
    .player_1_score(player_1_score),
    .player_2_score(player_2_score),
    .xpos_player_2(xpos_player_2),
    .ypos_player_2(ypos_player_2),
    .ai_state(ai_state)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  // Driver tasks. Each one returns 1 time unit after an active edge, so the
  // bench always samples outputs away from that edge.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic ticks(input int n);
    cycles(SD * n);
  endtask

  task automatic set_ball(input int x, input int y);
    xpos_ball = 12'(x);
    ypos_ball = 12'(y);
  endtask

  // Scoreboard
  task automatic check(input string tag, input int ex, input int ey, input int es);
    logic [25:0] exp_w, obs_w;
    exp_q.push_back({12'(ex), 12'(ey), 2'(es)});
    exp_w = exp_q.pop_front();
    obs_w = {xpos_player_2, ypos_player_2, ai_state};
    n_checks++;
    assert (obs_w === exp_w) n_pass++;
    else $error("FAIL %s: got x=%0d y=%0d st=%0d, expected x=%0d y=%0d st=%0d",
                tag, obs_w[25:14], obs_w[13:2], obs_w[1:0],
                exp_w[25:14], exp_w[13:2], exp_w[1:0]);
  endtask

  task automatic check_bounds(input int t);
    n_checks++;
    assert (xpos_player_2 >= 12'd532 && xpos_player_2 <= 12'd961 &&
            ypos_player_2 >= 12'd64  && ypos_player_2 <= 12'd707) n_pass++;
    else $error("FAIL bounds tick %0d: got x=%0d y=%0d, expected x in 532..961 y in 64..707",
                t, xpos_player_2, ypos_player_2);
  endtask

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b1;
    player_1_score = 4'd0;
    player_2_score = 4'd0;
    set_ball(487, 362);

    // Ball in the left half: the striker stays home
    do_reset();
    check("reset", 900, 362, 0);
    ticks(10);
    check("left_half_10", 900, 362, 0);
    cycles(2);
    do_reset();
    check("reset_midrun", 900, 362, 0);

    // Defend with the goal-mouth clamp
    set_ball(600, 200);
    do_reset();
    ticks(1);
    check("defend_t1", 900, 362, 1);
    ticks(10);
    check("defend_t11", 900, 352, 1);
    ticks(67);
    check("defend_t78", 900, 285, 1);
    ticks(1);
    check("defend_t79", 900, 285, 1);
    cycles(1);
    do_reset();
    check("reset_after_move", 900, 362, 0);

    // Attack sequence with the attack timeout bouncing back to DEFEND
    set_ball(800, 362);
    do_reset();
    ticks(1);
    check("attack_t1", 900, 362, 1);
    ticks(1);
    check("attack_t2", 900, 362, 2);
    ticks(28);
    check("attack_t30", 872, 362, 2);
    ticks(22);
    check("attack_t52", 850, 362, 1);
    ticks(1);
    check("attack_t53", 851, 362, 2);
    ticks(36);
    check("attack_t89", 815, 362, 2);
    ticks(14);
    check("attack_t103", 815, 362, 1);
    ticks(1);
    check("attack_t104", 816, 362, 2);

    // Goal during ATTACK, then a second goal that restarts the hold
    do_reset();
    ticks(10);
    check("goal_pre", 892, 362, 2);
    player_1_score = 4'd1;
    cycles(1);
    check("goal1_resp", 900, 362, 3);
    cycles(SD - 1);
    check("goal1_hold_t11", 900, 362, 3);
    player_2_score = 4'd1;
    cycles(1);
    check("goal2_resp", 900, 362, 3);
    cycles(SD - 1);
    ticks(1);
    check("hold_t13", 900, 362, 3);
    ticks(1);
    check("hold_end_t14", 900, 362, 0);
    ticks(1);
    check("after_hold_t15", 900, 362, 1);

    // Disable during ATTACK; the score copies reload on reset, so no false goal
    do_reset();
    check("reset_scores", 900, 362, 0);
    ticks(12);
    check("dis_pre_t12", 890, 362, 2);
    enable = 1'b0;
    ticks(1);
    check("dis_t13", 889, 362, 0);
    ticks(11);
    check("dis_t24", 900, 362, 0);
    ticks(1);
    check("dis_t25", 900, 362, 0);
    enable = 1'b1;

    // Bound clamp: ball beyond the striker limits in the corner
    set_ball(1000, 720);
    do_reset();
    for (int t = 1; t <= 357; t++) begin
      ticks(1);
      check_bounds(t);
      if (t == 2)   check("clamp_t2",   900, 363, 2);
      if (t == 52)  check("clamp_t52",  950, 413, 1);
      if (t == 53)  check("clamp_t53",  949, 414, 2);
      if (t == 65)  check("clamp_t65",  961, 426, 2);
      if (t == 104) check("clamp_t104", 960, 463, 2);
    end
    check("clamp_conv", 961, 707, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
